prism_sp_puzzle_fifo_write_arbiter: RTL and testbench
=====================================================

// Module: prism_sp_puzzle_fifo_write_arbiter
// PURPOSE
//  Shares one puzzle FIFO write port between NREQ requesters (HW puzzle engines and SW-side writers).
//  Arbitration is round-robin with packet locking: the grant holds until the owner's last beat is accepted.
//  An idle-owner watchdog reclaims a stuck grant. Sits between the requesters and the puzzle FIFO mixer's write side.
// PARAMETERS
//  NREQ     4   number of requesters, 2..8
//  DW       32  FIFO data width
//  TIMEOUT  256 BUSY cycles with no accepted beat before reclaim; 0 disables the watchdog
// PORTS
//  clock           in   1         single clock; all logic is rising-edge
//  reset           in   1         synchronous, active-high
//  req_en_mask     in   NREQ      per-requester enable (config); 0 = never granted
//  req_wr_en       in   NREQ      requester holds wr_en + data/last stable while req_full is high
//  req_wr_data     in   NREQ*DW   packed; requester i uses bits [i*DW +: DW]
//  req_wr_last     in   NREQ      beat is the final beat of the packet
//  req_full        out  NREQ      per-requester backpressure
//  fifo_wr_en      out  1         write strobe to the puzzle FIFO
//  fifo_wr_data    out  DW        write data to the puzzle FIFO
//  fifo_full       in   1         puzzle FIFO full
//  grant_valid     out  1         state is BUSY
//  grant_id        out  3         current or last owner index
//  timeout_pulse   out  1         1-cycle pulse when the watchdog reclaims a grant
//  pkt_count       out  32        packets completed (last beat accepted); wraps
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, grant_id=0, wd_cnt=0, pkt_count=0, timeout_pulse=0.
//   req_full is all-ones. fifo_wr_en=0. fifo_wr_data=0.
//  States: IDLE, BUSY.
//  IDLE:
//   - pending = req_wr_en & req_en_mask.
//   - If pending != 0: pick the first set bit at or after rr_ptr, wrapping modulo NREQ. Next state is BUSY with grant_id = winner.
//   - Arbitration latency is 1 cycle. No beat is accepted in IDLE.
//  BUSY, owner o:
//   - req_full[o] = fifo_full. Every other req_full bit is 1.
//   - fifo_wr_en = req_wr_en[o] & ~fifo_full (combinational).
//   - fifo_wr_data = req_wr_data[o]. fifo_wr_data is 0 when not BUSY.
//   - A beat is accepted when fifo_wr_en = 1.
//   - Accepted beat with req_wr_last[o]=1: next state IDLE, rr_ptr = (o+1) mod NREQ, pkt_count += 1.
//   - Back-to-back packets from one requester therefore have a 1-cycle gap, and other requesters get a turn first.
//  Watchdog:
//   - wd_cnt clears on entry to BUSY and on every accepted beat. Otherwise it increments each BUSY cycle, including cycles stalled by fifo_full.
//   - When TIMEOUT != 0 and wd_cnt reaches TIMEOUT-1 with no beat accepted that cycle:
//     next state IDLE, rr_ptr = (o+1) mod NREQ, timeout_pulse = 1 on the following cycle, pkt_count unchanged.
//  Mask change:
//   - Clearing req_en_mask[o] while BUSY does not revoke the grant. The packet completes or times out.
//   - The mask is only consulted in IDLE.
//  Simultaneous events: a last beat accepted in the same cycle the watchdog would fire counts as completion. No timeout_pulse is issued.
//  Reset asserted mid-packet: all state returns to reset values on the next edge. The partial packet already in the FIFO is not retracted.
//  grant_id holds its value in IDLE.
//  No combinational path from fifo_full to any req_wr_*. The combinational path from req_wr_en[o] to fifo_wr_en is permitted.
// TESTING
//  1. Single requester:
//     req 1, 3 beats (0xA0,0xA1,0xA2, last on 3rd), fifo_full=0.
//     -> grant_valid 1 cycle after request; 3 consecutive fifo_wr_en; returns to IDLE; pkt_count=1; rr_ptr=2.
//  2. Round-robin:
//     reqs 0,2,3 all pending with 1-beat packets, rr_ptr=0.
//     -> grant order 0,2,3,0...; each grant 2 cycles apart; no interleaved data.
//  3. Packet lock:
//     req 0 sends a 4-beat packet while req 1 is pending.
//     -> all 4 beats of req 0 are written before any beat of req 1; req_full[1]=1 throughout.
//  4. Backpressure:
//     fifo_full=1 for 5 cycles mid-packet, TIMEOUT=256.
//     -> fifo_wr_en=0 and req_full[o]=1 while full; data held; packet resumes intact; no timeout.
//  5. Watchdog:
//     TIMEOUT=8; owner stops after beat 1 of a 3-beat packet.
//     -> IDLE after 8 idle BUSY cycles; timeout_pulse=1 for 1 cycle; pkt_count unchanged; next requester granted.
//  6. Mask and reset:
//     - req_en_mask=0b0001 with req 1 pending -> req 1 is never granted.
//     - reset asserted mid-packet -> all outputs reach reset values the next cycle.

Source files
------------

// File: rtl/prism_sp_puzzle_fifo_write_arbiter.sv
// Round-robin, packet-locked arbiter sharing one puzzle FIFO write port among NREQ requesters,
// with an idle-owner watchdog that reclaims a grant whose owner stops sending beats.
module prism_sp_puzzle_fifo_write_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NREQ-1:0]    req_en_mask_i,
    input  logic [NREQ-1:0]    req_wr_en_i,
    input  logic [NREQ*DW-1:0] req_wr_data_i,
    input  logic [NREQ-1:0]    req_wr_last_i,
    output logic [NREQ-1:0]    req_full_o,
    output logic               fifo_wr_en_o,
    output logic [DW-1:0]      fifo_wr_data_o,
    input  logic               fifo_full_i,
    output logic               grant_valid_o,
    output logic [2:0]         grant_id_o,
    output logic               timeout_pulse_o,
    output logic [31:0]        pkt_count_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic [31:0]     pkt_q, pkt_d;
    logic            tp_q, tp_d;

    logic [NREQ-1:0] pending;
    logic            found;
    logic [IW-1:0]   win;
    int              idx;
    logic            owner_wr_en, owner_last;
    logic [DW-1:0]   owner_data;
    logic            busy, accept, wd_fire;
    logic [IW-1:0]   next_ptr;

    assign pending = req_wr_en_i & req_en_mask_i;
    assign busy    = (state_q == BUSY);

    // First pending requester at or after rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && pending[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        owner_wr_en = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == owner_q) begin
                owner_wr_en = req_wr_en_i[i];
                owner_last  = req_wr_last_i[i];
                owner_data  = req_wr_data_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        req_full_o = '1;
        if (busy) req_full_o[owner_q] = fifo_full_i;
    end

    assign accept         = busy & owner_wr_en & ~fifo_full_i;
    assign fifo_wr_en_o   = accept;
    assign fifo_wr_data_o = busy ? owner_data : '0;
    assign next_ptr       = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
    // A last beat accepted in the firing cycle wins over the watchdog.
    assign wd_fire        = (TIMEOUT != 0) && (wd_q == WW'(TIMEOUT - 1)) && !accept;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        pkt_d   = pkt_q;
        tp_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    owner_d = win;
                    wd_d    = '0;
                end
            end
            BUSY: begin
                if (accept) begin
                    wd_d = '0;
                    if (owner_last) begin
                        state_d = IDLE;
                        rr_d    = next_ptr;
                        pkt_d   = pkt_q + 32'd1;
                    end
                end else if (wd_fire) begin
                    state_d = IDLE;
                    rr_d    = next_ptr;
                    tp_d    = 1'b1;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            wd_q    <= '0;
            pkt_q   <= '0;
            tp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
            pkt_q   <= pkt_d;
            tp_q    <= tp_d;
        end
    end

    assign grant_valid_o   = busy;
    assign grant_id_o      = 3'(owner_q);
    assign timeout_pulse_o = tp_q;
    assign pkt_count_o     = pkt_q;

endmodule

// File: tb/tb_prism_sp_puzzle_fifo_write_arbiter.sv
// Randomized bench: requesters with random packets, stalls, mask changes, FIFO-full bursts and resets,
// checked against a transaction-level model; FIFO writes go through a scoreboard queue.
module tb_prism_sp_puzzle_fifo_write_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;
    localparam int NCYC    = 4000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_en_mask;
    logic [NREQ-1:0]    req_wr_en;
    logic [NREQ*DW-1:0] req_wr_data;
    logic [NREQ-1:0]    req_wr_last;
    logic [NREQ-1:0]    req_full;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_wr_data;
    logic               fifo_full;
    logic               grant_valid;
    logic [2:0]         grant_id;
    logic               timeout_pulse;
    logic [31:0]        pkt_count;

    always #5 clk = ~clk;

    prism_sp_puzzle_fifo_write_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .req_en_mask_i  (req_en_mask),
        .req_wr_en_i    (req_wr_en),
        .req_wr_data_i  (req_wr_data),
        .req_wr_last_i  (req_wr_last),
        .req_full_o     (req_full),
        .fifo_wr_en_o   (fifo_wr_en),
        .fifo_wr_data_o (fifo_wr_data),
        .fifo_full_i    (fifo_full),
        .grant_valid_o  (grant_valid),
        .grant_id_o     (grant_id),
        .timeout_pulse_o(timeout_pulse),
        .pkt_count_o    (pkt_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            src;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: who owns the port, whose turn is next, how long the owner has made no progress.
    bit          m_busy   = 0;
    int          m_owner  = 0;
    int          m_turn   = 0;
    int          m_stall  = 0;
    int unsigned m_pkts   = 0;
    bit          m_tp     = 0;
    bit          armed    = 0;
    bit          cyc_chk  = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_full;
        logic [DW-1:0]   e_data;
        bit              e_wr;
        bit              found;
        int              j;
        e_full = '1;
        e_data = '0;
        e_wr   = 0;
        if (m_busy) begin
            e_full[m_owner] = fifo_full;
            e_data = req_wr_data[m_owner*DW +: DW];
            e_wr   = req_wr_en[m_owner] && !fifo_full;
        end
        cyc_chk = armed;
        if (armed) begin
            chk("grant_valid", 64'(grant_valid), 64'(m_busy));
            chk("grant_id", 64'(grant_id), 64'(m_owner));
            chk("timeout_pulse", 64'(timeout_pulse), 64'(m_tp));
            chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
            chk("req_full", 64'(req_full), 64'(e_full));
            chk("wr_data_idle", 64'(fifo_wr_data), 64'(e_data));
            if (e_wr) exp_q.push_back('{data: e_data, src: m_owner});
        end
        if (rst) begin
            m_busy = 0; m_owner = 0; m_turn = 0; m_stall = 0; m_pkts = 0; m_tp = 0;
            armed = 1;
        end else begin
            m_tp = 0;
            if (!m_busy) begin
                found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    j = (m_turn + k) % NREQ;
                    if (!found && req_wr_en[j] && req_en_mask[j]) begin
                        found = 1; m_busy = 1; m_owner = j; m_stall = 0;
                    end
                end
            end else if (e_wr) begin
                m_stall = 0;
                if (req_wr_last[m_owner]) begin
                    m_busy = 0; m_turn = (m_owner + 1) % NREQ; m_pkts++;
                end
            end else begin
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    m_busy = 0; m_turn = (m_owner + 1) % NREQ; m_tp = 1;
                end
            end
        end
    end

    // Scoreboard monitor: every DUT write must match the oldest predicted write.
    always @(negedge clk) begin
        wr_t e;
        #1;
        if (cyc_chk) begin
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got data 0x%0h, expected no write at %0t", fifo_wr_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_beat", 64'(fifo_wr_data), 64'(e.data));
                end
            end else if (exp_q.size() != 0) begin
                tests++; fails++;
                $display("FAIL missing_write: got no write, expected data 0x%0h at %0t", exp_q[0].data, $time);
                exp_q.delete();
            end
        end
    end

    initial begin
        logic [NREQ-1:0] acc;
        int left [NREQ];
        int seq  [NREQ];
        int quiet[NREQ];
        int full_cnt;
        req_en_mask = '1;
        req_wr_en   = '0;
        req_wr_data = '0;
        req_wr_last = '0;
        fifo_full   = 1'b0;
        full_cnt    = 0;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0; seq[i] = 0; quiet[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            acc = req_wr_en & ~req_full;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 599) == 0);
            if (full_cnt > 0) full_cnt--;
            else if ($urandom_range(0, 9) == 0) full_cnt = $urandom_range(1, 6);
            fifo_full = (full_cnt > 0);
            if ($urandom_range(0, 149) == 0)
                req_en_mask = ($urandom_range(0, 3) == 0) ? NREQ'(1) : NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    left[i]--;
                    if ($urandom_range(0, 24) == 0) quiet[i] = $urandom_range(9, 14);
                end
                if (req_wr_en[i] && !acc[i]) continue;
                if (left[i] <= 0) left[i] = $urandom_range(1, 4);
                if (quiet[i] > 0) begin
                    quiet[i]--;
                    req_wr_en[i] = 1'b0;
                end else begin
                    req_wr_en[i] = ($urandom_range(0, 3) != 0);
                end
                req_wr_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
                req_wr_last[i] = (left[i] == 1);
            end
        end
        @(negedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
